// File: rtl/tft_cmd_decoder.sv
// tft_cmd_decoder: deserialises the write-only TFT SPI stream and decodes the
// ILI9341-style command subset (CASET/PASET/RAMWR/SWRESET) into pixel writes.
module tft_cmd_decoder #(
   parameter int COORD_W = 9,
   parameter int WIDTH   = 240,
   parameter int HEIGHT  = 320
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               spi_clk,
   input  logic               spi_mosi,
   input  logic               spi_dc,
   input  logic               spi_cs,
   output logic               byte_valid,
   output logic [7:0]         byte_data,
   output logic               byte_dc,
   output logic               cmd_valid,
   output logic [7:0]         cmd_code,
   output logic               pixel_valid,
   output logic [COORD_W-1:0] pixel_x,
   output logic [COORD_W-1:0] pixel_y,
   output logic [15:0]        pixel_data
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PARAM,
      ST_RAMWR_HI,
      ST_RAMWR_LO,
      ST_SKIP
   } state_t;

   localparam logic [COORD_W-1:0] XE_RST = COORD_W'(WIDTH - 1);
   localparam logic [COORD_W-1:0] YE_RST = COORD_W'(HEIGHT - 1);

   // synchroniser bits: [0]=spi_clk [1]=mosi [2]=dc [3]=cs
   logic [3:0] sync1_q, sync1_d, sync2_q, sync2_d;
   logic       clk_prev_q, clk_prev_d;
   logic       clk_rise, mosi_s, dc_s, cs_s;

   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [6:0] shreg_q, shreg_d;
   logic       byte_valid_q, byte_valid_d;
   logic [7:0] byte_data_q, byte_data_d;
   logic       byte_dc_q, byte_dc_d;

   state_t               state_q, state_d;
   logic                 tgt_y_q, tgt_y_d;
   logic [1:0]           pidx_q, pidx_d;
   logic [7:0]           param_hi_q, param_hi_d;
   logic [COORD_W-1:0]   start_q, start_d;
   logic [COORD_W-1:0]   xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
   logic [COORD_W-1:0]   cur_x_q, cur_x_d, cur_y_q, cur_y_d;
   logic [7:0]           hi_byte_q, hi_byte_d;
   logic                 cmd_valid_q, cmd_valid_d;
   logic [7:0]           cmd_code_q, cmd_code_d;
   logic                 pixel_valid_q, pixel_valid_d;
   logic [COORD_W-1:0]   pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
   logic [15:0]          pixel_data_q, pixel_data_d;
   logic [COORD_W-1:0]   coord;

   // two-flop synchroniser inputs and rising-edge detect on synced spi_clk
   always_comb begin
      sync1_d    = {spi_cs, spi_dc, spi_mosi, spi_clk};
      sync2_d    = sync1_q;
      clk_prev_d = sync2_q[0];
      clk_rise   = sync2_q[0] & ~clk_prev_q;
      mosi_s     = sync2_q[1];
      dc_s       = sync2_q[2];
      cs_s       = sync2_q[3];
   end

   // synchroniser flops run freely, also during reset, so no false edge follows reset release
   always_ff @(posedge clk) begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      clk_prev_q <= clk_prev_d;
   end

   // bit shifter: assemble MSB-first bytes, drop partial byte while deselected
   always_comb begin
      bit_cnt_d    = bit_cnt_q;
      shreg_d      = shreg_q;
      byte_valid_d = 1'b0;
      byte_data_d  = byte_data_q;
      byte_dc_d    = byte_dc_q;
      if (cs_s) begin
         bit_cnt_d = '0;
      end else if (clk_rise) begin
         shreg_d   = {shreg_q[5:0], mosi_s};
         bit_cnt_d = bit_cnt_q + 3'd1;
         if (bit_cnt_q == 3'd7) begin
            byte_valid_d = 1'b1;
            byte_data_d  = {shreg_q, mosi_s};
            byte_dc_d    = dc_s;
         end
      end
   end

   // command decoder FSM: next state, window/cursor updates and output pulses
   always_comb begin
      state_d       = state_q;
      tgt_y_d       = tgt_y_q;
      pidx_d        = pidx_q;
      param_hi_d    = param_hi_q;
      start_d       = start_q;
      xs_d          = xs_q;
      xe_d          = xe_q;
      ys_d          = ys_q;
      ye_d          = ye_q;
      cur_x_d       = cur_x_q;
      cur_y_d       = cur_y_q;
      hi_byte_d     = hi_byte_q;
      cmd_valid_d   = 1'b0;
      cmd_code_d    = cmd_code_q;
      pixel_valid_d = 1'b0;
      pixel_x_d     = pixel_x_q;
      pixel_y_d     = pixel_y_q;
      pixel_data_d  = pixel_data_q;
      // 16-bit parameter word truncated to the coordinate width
      coord         = COORD_W'({param_hi_q, byte_data_q});
      if (byte_valid_q) begin
         if (!byte_dc_q) begin
            cmd_valid_d = 1'b1;
            cmd_code_d  = byte_data_q;
            case (byte_data_q)
               8'h2A: begin
                  state_d = ST_PARAM;
                  tgt_y_d = 1'b0;
                  pidx_d  = '0;
               end
               8'h2B: begin
                  state_d = ST_PARAM;
                  tgt_y_d = 1'b1;
                  pidx_d  = '0;
               end
               8'h2C: begin
                  state_d = ST_RAMWR_HI;
                  cur_x_d = xs_q;
                  cur_y_d = ys_q;
               end
               8'h01: begin
                  state_d = ST_IDLE;
                  xs_d    = '0;
                  xe_d    = XE_RST;
                  ys_d    = '0;
                  ye_d    = YE_RST;
               end
               default: state_d = ST_SKIP;
            endcase
         end else begin
            case (state_q)
               ST_PARAM: begin
                  pidx_d = pidx_q + 2'd1;
                  case (pidx_q)
                     2'd0:    param_hi_d = byte_data_q;
                     2'd1:    start_d    = coord;
                     2'd2:    param_hi_d = byte_data_q;
                     default: begin
                        if (tgt_y_q) begin
                           ys_d = start_q;
                           ye_d = coord;
                        end else begin
                           xs_d = start_q;
                           xe_d = coord;
                        end
                        state_d = ST_IDLE;
                     end
                  endcase
               end
               ST_RAMWR_HI: begin
                  hi_byte_d = byte_data_q;
                  state_d   = ST_RAMWR_LO;
               end
               ST_RAMWR_LO: begin
                  pixel_valid_d = 1'b1;
                  pixel_x_d     = cur_x_q;
                  pixel_y_d     = cur_y_q;
                  pixel_data_d  = {hi_byte_q, byte_data_q};
                  if (cur_x_q >= xe_q) begin
                     cur_x_d = xs_q;
                     cur_y_d = (cur_y_q >= ye_q) ? ys_q : cur_y_q + 1'b1;
                  end else begin
                     cur_x_d = cur_x_q + 1'b1;
                  end
                  state_d = ST_RAMWR_HI;
               end
               default: ;
            endcase
         end
      end
   end

   // state register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         bit_cnt_q     <= '0;
         shreg_q       <= '0;
         byte_valid_q  <= 1'b0;
         byte_data_q   <= '0;
         byte_dc_q     <= 1'b0;
         state_q       <= ST_IDLE;
         tgt_y_q       <= 1'b0;
         pidx_q        <= '0;
         param_hi_q    <= '0;
         start_q       <= '0;
         xs_q          <= '0;
         xe_q          <= XE_RST;
         ys_q          <= '0;
         ye_q          <= YE_RST;
         cur_x_q       <= '0;
         cur_y_q       <= '0;
         hi_byte_q     <= '0;
         cmd_valid_q   <= 1'b0;
         cmd_code_q    <= '0;
         pixel_valid_q <= 1'b0;
         pixel_x_q     <= '0;
         pixel_y_q     <= '0;
         pixel_data_q  <= '0;
      end else begin
         bit_cnt_q     <= bit_cnt_d;
         shreg_q       <= shreg_d;
         byte_valid_q  <= byte_valid_d;
         byte_data_q   <= byte_data_d;
         byte_dc_q     <= byte_dc_d;
         state_q       <= state_d;
         tgt_y_q       <= tgt_y_d;
         pidx_q        <= pidx_d;
         param_hi_q    <= param_hi_d;
         start_q       <= start_d;
         xs_q          <= xs_d;
         xe_q          <= xe_d;
         ys_q          <= ys_d;
         ye_q          <= ye_d;
         cur_x_q       <= cur_x_d;
         cur_y_q       <= cur_y_d;
         hi_byte_q     <= hi_byte_d;
         cmd_valid_q   <= cmd_valid_d;
         cmd_code_q    <= cmd_code_d;
         pixel_valid_q <= pixel_valid_d;
         pixel_x_q     <= pixel_x_d;
         pixel_y_q     <= pixel_y_d;
         pixel_data_q  <= pixel_data_d;
      end
   end

   assign byte_valid  = byte_valid_q;
   assign byte_data   = byte_data_q;
   assign byte_dc     = byte_dc_q;
   assign cmd_valid   = cmd_valid_q;
   assign cmd_code    = cmd_code_q;
   assign pixel_valid = pixel_valid_q;
   assign pixel_x     = pixel_x_q;
   assign pixel_y     = pixel_y_q;
   assign pixel_data  = pixel_data_q;

endmodule

// File: tb/tb_tft_cmd_decoder.sv
// tb_tft_cmd_decoder: drives SPI traffic into tft_cmd_decoder and checks every
// output pulse against a window/pixel-index model of the display command set.
module tb_tft_cmd_decoder;
   localparam int CW = 9;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          spi_clk = 1'b0;
   logic          spi_mosi = 1'b0;
   logic          spi_dc = 1'b0;
   logic          spi_cs = 1'b1;
   logic          byte_valid;
   logic [7:0]    byte_data;
   logic          byte_dc;
   logic          cmd_valid;
   logic [7:0]    cmd_code;
   logic          pixel_valid;
   logic [CW-1:0] pixel_x;
   logic [CW-1:0] pixel_y;
   logic [15:0]   pixel_data;

   always #5 clk = ~clk;

   tft_cmd_decoder #(.COORD_W(CW), .WIDTH(240), .HEIGHT(320)) dut (
      .clk(clk), .rst(rst),
      .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_dc(spi_dc), .spi_cs(spi_cs),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_dc(byte_dc),
      .cmd_valid(cmd_valid), .cmd_code(cmd_code),
      .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .pixel_data(pixel_data)
   );

   int n_vec  = 0;
   int n_miss = 0;
   int half   = 3;

   // reference model: window bounds, current command and bytes seen since it
   int win_xs, win_xe, win_ys, win_ye;
   int cur_cmd, nbytes, pix_hi;
   int prm [4];

   int            exp_byte_q [$];
   int            exp_cmd_q  [$];
   logic [33:0]   exp_pix_q  [$];
   logic [33:0]   pix_log    [$];
   int            byte_cnt = 0;
   logic [8:0]    last_byte = '0;
   logic [7:0]    last_cmd  = '0;

   task automatic model_reset();
      win_xs = 0; win_xe = 239; win_ys = 0; win_ye = 319;
      cur_cmd = -1; nbytes = 0; pix_hi = 0;
   endtask

   // pixel n of a RAMWR burst lands at a position found by plain index arithmetic
   task automatic model_byte(input int b, input int dc);
      int s, e, n, w, h, x, y;
      exp_byte_q.push_back((dc << 8) | b);
      if (dc == 0) begin
         exp_cmd_q.push_back(b);
         cur_cmd = b;
         nbytes  = 0;
         if (b == 8'h01) begin
            win_xs = 0; win_xe = 239; win_ys = 0; win_ye = 319;
         end
      end else begin
         if ((cur_cmd == 8'h2A || cur_cmd == 8'h2B) && nbytes < 4) begin
            prm[nbytes] = b;
            if (nbytes == 3) begin
               s = ((prm[0] << 8) | prm[1]) % (1 << CW);
               e = ((prm[2] << 8) | prm[3]) % (1 << CW);
               if (cur_cmd == 8'h2A) begin win_xs = s; win_xe = e; end
               else begin win_ys = s; win_ye = e; end
            end
         end else if (cur_cmd == 8'h2C) begin
            if (nbytes % 2 == 0) pix_hi = b;
            else begin
               n = nbytes / 2;
               w = (win_xe >= win_xs) ? win_xe - win_xs + 1 : 1;
               h = (win_ye >= win_ys) ? win_ye - win_ys + 1 : 1;
               x = win_xs + n % w;
               y = win_ys + (n / w) % h;
               exp_pix_q.push_back({9'(x), 9'(y), 8'(pix_hi), 8'(b)});
            end
         end
         nbytes++;
      end
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // compare process: every output pulse must match the next model expectation
   always @(posedge clk) begin
      int e;
      logic [33:0] ep;
      #1;
      if (rst) begin
         if (byte_valid) begin
            byte_cnt++;
            last_byte = {byte_dc, byte_data};
            n_vec++;
            if (exp_byte_q.size() == 0) begin
               n_miss++;
               $display("FAIL byte: unexpected byte dc=%b data=%h", byte_dc, byte_data);
            end else begin
               e = exp_byte_q.pop_front();
               if ({byte_dc, byte_data} !== e[8:0]) begin
                  n_miss++;
                  $display("FAIL byte: got %h expected %h", {byte_dc, byte_data}, e[8:0]);
               end
            end
         end
         if (cmd_valid) begin
            last_cmd = cmd_code;
            n_vec++;
            if (exp_cmd_q.size() == 0) begin
               n_miss++;
               $display("FAIL cmd: unexpected cmd_code=%h", cmd_code);
            end else begin
               e = exp_cmd_q.pop_front();
               if (cmd_code !== e[7:0]) begin
                  n_miss++;
                  $display("FAIL cmd: got %h expected %h", cmd_code, e[7:0]);
               end
            end
         end
         if (pixel_valid) begin
            pix_log.push_back({pixel_x, pixel_y, pixel_data});
            n_vec++;
            if (exp_pix_q.size() == 0) begin
               n_miss++;
               $display("FAIL pixel: unexpected (%0d,%0d)=%h", pixel_x, pixel_y, pixel_data);
            end else begin
               ep = exp_pix_q.pop_front();
               if ({pixel_x, pixel_y, pixel_data} !== ep) begin
                  n_miss++;
                  $display("FAIL pixel: got (%0d,%0d)=%h expected (%0d,%0d)=%h",
                           pixel_x, pixel_y, pixel_data, ep[33:25], ep[24:16], ep[15:0]);
               end
            end
         end
      end
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bits(input logic [7:0] b, input logic dc, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         spi_clk  = 1'b0;
         spi_mosi = b[7-i];
         spi_dc   = dc;
         wait_clks(half);
         spi_clk = 1'b1;
         wait_clks(half);
      end
      spi_clk = 1'b0;
   endtask

   task automatic send_byte(input int b, input int dc);
      model_byte(b, dc);
      send_bits(8'(b), dc[0], 8);
   endtask

   task automatic drain();
      int t = 0;
      while ((exp_byte_q.size() + exp_cmd_q.size() + exp_pix_q.size()) != 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      wait_clks(4);
      chk("drain_bytes", 64'(exp_byte_q.size()), 64'd0);
      chk("drain_cmds", 64'(exp_cmd_q.size()), 64'd0);
      chk("drain_pixels", 64'(exp_pix_q.size()), 64'd0);
   endtask

   function automatic logic [33:0] log_at(input int i);
      if (i < pix_log.size()) return pix_log[i];
      return '1;
   endfunction

   task automatic do_reset();
      rst = 1'b0;
      wait_clks(5);
      chk("reset_outputs",
          64'({byte_valid, byte_data, byte_dc, cmd_valid, cmd_code,
               pixel_valid, pixel_x, pixel_y, pixel_data}), 64'd0);
      exp_byte_q.delete();
      exp_cmd_q.delete();
      exp_pix_q.delete();
      model_reset();
      rst = 1'b1;
      wait_clks(3);
   endtask

   initial begin
      #950000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int c, b, r, k, bc0;
      model_reset();
      do_reset();
      spi_cs = 1'b0;
      wait_clks(4);

      // single command byte
      send_byte(8'h2A, 0);
      drain();
      chk("t1_byte", 64'(last_byte), 64'h02A);
      chk("t1_cmd", 64'(last_cmd), 64'h2A);

      // 2x2 window, 5th pixel wraps back to the origin
      pix_log.delete();
      send_byte(8'h2A, 0);
      send_byte(8'h00, 1); send_byte(8'h0A, 1); send_byte(8'h00, 1); send_byte(8'h0B, 1);
      send_byte(8'h2B, 0);
      send_byte(8'h00, 1); send_byte(8'h05, 1); send_byte(8'h00, 1); send_byte(8'h06, 1);
      send_byte(8'h2C, 0);
      send_byte(8'hF8, 1); send_byte(8'h00, 1); send_byte(8'h07, 1); send_byte(8'hE0, 1);
      send_byte(8'h00, 1); send_byte(8'h1F, 1); send_byte(8'hFF, 1); send_byte(8'hFF, 1);
      send_byte(8'h12, 1); send_byte(8'h34, 1);
      drain();
      chk("t2_count", 64'(pix_log.size()), 64'd5);
      chk("t2_px0", 64'(log_at(0)), 64'({9'd10, 9'd5, 16'hF800}));
      chk("t2_px1", 64'(log_at(1)), 64'({9'd11, 9'd5, 16'h07E0}));
      chk("t2_px2", 64'(log_at(2)), 64'({9'd10, 9'd6, 16'h001F}));
      chk("t2_px3", 64'(log_at(3)), 64'({9'd11, 9'd6, 16'hFFFF}));
      chk("t2_px4", 64'(log_at(4)), 64'({9'd10, 9'd5, 16'h1234}));

      // default window: full row then step to row 1
      do_reset();
      pix_log.delete();
      send_byte(8'h2C, 0);
      for (int i = 0; i < 482; i++) send_byte(int'($urandom_range(0, 255)), 1);
      drain();
      chk("t3_count", 64'(pix_log.size()), 64'd241);
      chk("t3_px0_xy", 64'(log_at(0) >> 16), 64'({9'd0, 9'd0}));
      chk("t3_px239_xy", 64'(log_at(239) >> 16), 64'({9'd239, 9'd0}));
      chk("t3_px240_xy", 64'(log_at(240) >> 16), 64'({9'd0, 9'd1}));

      // aborted CASET leaves window untouched
      pix_log.delete();
      send_byte(8'h2A, 0); send_byte(8'h00, 1); send_byte(8'h0A, 1); send_byte(8'h00, 1);
      send_byte(8'h2C, 0); send_byte(8'hAB, 1); send_byte(8'hCD, 1);
      drain();
      chk("t4_px0", 64'(log_at(0)), 64'({9'd0, 9'd0, 16'hABCD}));

      // pending high byte discarded by a new command
      pix_log.delete();
      send_byte(8'h2C, 0); send_byte(8'hF8, 1); send_byte(8'h00, 0);
      for (int i = 0; i < 4; i++) send_byte(int'($urandom_range(0, 255)), 1);
      drain();
      chk("t5_no_pixels", 64'(pix_log.size()), 64'd0);
      chk("t5_cmd", 64'(last_cmd), 64'h00);

      // cs deselect drops a partial byte
      bc0 = byte_cnt;
      send_bits(8'hA5, 1'b1, 5);
      spi_cs = 1'b1;
      wait_clks(6);
      spi_cs = 1'b0;
      wait_clks(4);
      send_byte(8'h2C, 0);
      drain();
      chk("t6_byte", 64'(last_byte), 64'h02C);
      chk("t6_single_pulse", 64'(byte_cnt - bc0), 64'd1);

      // reversed X window and truncated coordinates
      pix_log.delete();
      send_byte(8'h2A, 0); send_byte(8'h00, 1); send_byte(8'h05, 1); send_byte(8'h00, 1); send_byte(8'h03, 1);
      send_byte(8'h2B, 0); send_byte(8'h02, 1); send_byte(8'h02, 1); send_byte(8'h02, 1); send_byte(8'h03, 1);
      send_byte(8'h2C, 0);
      for (int i = 0; i < 6; i++) send_byte(i, 1);
      drain();
      chk("t7_px2_xy", 64'(log_at(2) >> 16), 64'({9'd5, 9'd2}));

      // reset mid-RAMWR and mid-byte: back to idle, window defaults
      send_byte(8'h2C, 0); send_byte(8'h11, 1);
      drain();
      send_bits(8'hFF, 1'b1, 3);
      do_reset();
      pix_log.delete();
      send_byte(8'h22, 1); send_byte(8'h33, 1);
      send_byte(8'h2C, 0); send_byte(8'h44, 1); send_byte(8'h55, 1);
      drain();
      chk("t8_px0", 64'(log_at(0)), 64'({9'd0, 9'd0, 16'h4455}));
      chk("t8_count", 64'(pix_log.size()), 64'd1);

      // randomized command/data stream at varying link rates
      for (int i = 0; i < 250; i++) begin
         half = int'($urandom_range(3, 5));
         r = int'($urandom_range(0, 99));
         if (r < 20) begin
            k = int'($urandom_range(0, 5));
            case (k)
               0: c = 8'h2A;
               1: c = 8'h2B;
               2, 3: c = 8'h2C;
               4: c = 8'h01;
               default: c = int'($urandom_range(0, 255));
            endcase
            send_byte(c, 0);
         end else begin
            b = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255));
            send_byte(b, 1);
         end
         if ($urandom_range(0, 15) == 0) begin
            spi_cs = 1'b1;
            wait_clks(5);
            spi_cs = 1'b0;
            wait_clks(3);
         end
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
